// File: rtl/seq_arithmetic_unit.sv
// Multi-cycle arithmetic unit: ADD/SUB/INC/DEC in one clock, MUL by shift-add and
// DIV by restoring division over WORD_SIZE iterations, with valid/ready on both sides.
module seq_arithmetic_unit #(
   parameter int WORD_SIZE   = 19,
   parameter int OPCODE_SIZE = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OPCODE_SIZE-1:0] opcode,
   input  logic [WORD_SIZE-1:0]   operand_1,
   input  logic [WORD_SIZE-1:0]   operand_2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_SIZE-1:0]   result,
   output logic [WORD_SIZE-1:0]   result_hi,
   output logic                   carry,
   output logic                   zero,
   output logic                   overflow,
   output logic                   div_by_zero,
   output logic                   illegal_op
);

   localparam int CNT_W = $clog2(WORD_SIZE + 1);
   localparam int MSB   = WORD_SIZE - 1;

   localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(0);
   localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(1);
   localparam logic [OPCODE_SIZE-1:0] OP_MUL = OPCODE_SIZE'(2);
   localparam logic [OPCODE_SIZE-1:0] OP_DIV = OPCODE_SIZE'(3);
   localparam logic [OPCODE_SIZE-1:0] OP_INC = OPCODE_SIZE'(4);
   localparam logic [OPCODE_SIZE-1:0] OP_DEC = OPCODE_SIZE'(5);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic [OPCODE_SIZE-1:0] op_r;
   logic [WORD_SIZE-1:0]   a_r, b_r;
   logic [WORD_SIZE-1:0]   work_hi, work_lo;

   logic [WORD_SIZE:0]     mul_sum, div_shift, div_diff, ext;
   logic [WORD_SIZE-1:0]   fin_res, fin_hi;
   logic                   fin_carry, fin_zero, fin_ovf, fin_dbz, fin_ill;
   logic                   long_op;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign long_op   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_2 != '0));

   // work_hi is the running partial product / remainder; work_lo holds the
   // unconsumed multiplier bits or the dividend shifting out as quotient shifts in.
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_r} : '0);
      div_shift = {work_hi, work_lo[MSB]};
      div_diff  = div_shift - {1'b0, b_r};
   end

   always_comb begin
      ext       = '0;
      fin_res   = '0;
      fin_hi    = '0;
      fin_carry = 1'b0;
      fin_ovf   = 1'b0;
      fin_dbz   = 1'b0;
      fin_ill   = 1'b0;
      fin_zero  = 1'b0;
      case (op_r)
         OP_ADD: begin
            ext       = {1'b0, a_r} + {1'b0, b_r};
            fin_res   = ext[MSB:0];
            fin_carry = ext[WORD_SIZE];
            fin_ovf   = (a_r[MSB] == b_r[MSB]) && (ext[MSB] != a_r[MSB]);
            fin_zero  = (fin_res == '0);
         end
         OP_SUB: begin
            ext       = {1'b0, a_r} - {1'b0, b_r};
            fin_res   = ext[MSB:0];
            fin_carry = ext[WORD_SIZE];
            fin_ovf   = (a_r[MSB] != b_r[MSB]) && (ext[MSB] != a_r[MSB]);
            fin_zero  = (fin_res == '0);
         end
         OP_INC: begin
            ext       = {1'b0, a_r} + (WORD_SIZE+1)'(1);
            fin_res   = ext[MSB:0];
            fin_carry = ext[WORD_SIZE];
            fin_ovf   = ext[MSB] && !a_r[MSB];
            fin_zero  = (fin_res == '0);
         end
         OP_DEC: begin
            ext       = {1'b0, a_r} - (WORD_SIZE+1)'(1);
            fin_res   = ext[MSB:0];
            fin_carry = ext[WORD_SIZE];
            fin_ovf   = !ext[MSB] && a_r[MSB];
            fin_zero  = (fin_res == '0);
         end
         OP_MUL: begin
            fin_res  = work_lo;
            fin_hi   = work_hi;
            fin_ovf  = (work_hi != '0);
            fin_zero = (work_lo == '0) && (work_hi == '0);
         end
         OP_DIV: begin
            if (b_r == '0) begin
               fin_res = '1;
               fin_hi  = a_r;
               fin_dbz = 1'b1;
            end else begin
               fin_res  = work_lo;
               fin_hi   = work_hi;
               fin_zero = (work_lo == '0);
            end
         end
         default: fin_ill = 1'b1;
      endcase
   end

   // Every op passes through BUSY; single-cycle ops enter with cnt = 0 so
   // results always latch on the BUSY->DONE edge from registered operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         work_hi     <= '0;
         work_lo     <= '0;
         result      <= '0;
         result_hi   <= '0;
         carry       <= 1'b0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_r    <= opcode;
                  a_r     <= operand_1;
                  b_r     <= operand_2;
                  work_hi <= '0;
                  work_lo <= operand_1;
                  cnt     <= long_op ? CNT_W'(WORD_SIZE) : '0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
                  if (op_r == OP_MUL) begin
                     work_hi <= mul_sum[WORD_SIZE:1];
                     work_lo <= {mul_sum[0], work_lo[MSB:1]};
                  end else if (!div_diff[WORD_SIZE]) begin
                     work_hi <= div_diff[MSB:0];
                     work_lo <= {work_lo[MSB-1:0], 1'b1};
                  end else begin
                     work_hi <= div_shift[MSB:0];
                     work_lo <= {work_lo[MSB-1:0], 1'b0};
                  end
               end else begin
                  result      <= fin_res;
                  result_hi   <= fin_hi;
                  carry       <= fin_carry;
                  zero        <= fin_zero;
                  overflow    <= fin_ovf;
                  div_by_zero <= fin_dbz;
                  illegal_op  <= fin_ill;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Bench for seq_arithmetic_unit: directed cases plus random ops checked against an
// arithmetic reference model (wide integer math, signed range test for overflow).
module tb_seq_arithmetic_unit;

   localparam int W = 19;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_INC = 3'd4;
   localparam logic [2:0] OP_DEC = 3'd5;
   localparam logic [2:0] OP_BAD = 3'd6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   opcode = '0;
   logic [W-1:0] operand_1 = '0;
   logic [W-1:0] operand_2 = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result, result_hi;
   logic         carry, zero, overflow, div_by_zero, illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      longint unsigned res;
      longint unsigned hi;
      bit c, z, o, d, i;
      int lat;
   } exp_t;

   seq_arithmetic_unit #(.WORD_SIZE(W), .OPCODE_SIZE(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .operand_1(operand_1), .operand_2(operand_2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .carry(carry), .zero(zero), .overflow(overflow),
      .div_by_zero(div_by_zero), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint signed as_signed(longint unsigned v);
      return (v >= (64'd1 << (W-1))) ? longint'(v) - longint'(64'd1 << W) : longint'(v);
   endfunction

   function automatic exp_t model(logic [2:0] op, longint unsigned a, longint unsigned b);
      exp_t e;
      longint unsigned mask = (64'd1 << W) - 1;
      longint signed   smax = longint'(64'd1 << (W-1)) - 1;
      longint signed   smin = -longint'(64'd1 << (W-1));
      longint signed   st;
      longint unsigned p;
      e = '{res: 0, hi: 0, c: 0, z: 0, o: 0, d: 0, i: 0, lat: 1};
      if (op == OP_INC) b = 1;
      if (op == OP_DEC) b = 1;
      case (op)
         OP_ADD, OP_INC: begin
            e.res = (a + b) & mask;
            e.c   = ((a + b) > mask);
            st    = as_signed(a) + as_signed(b);
            e.o   = (st > smax) || (st < smin);
            e.z   = (e.res == 0);
         end
         OP_SUB, OP_DEC: begin
            e.res = (a - b) & mask;
            e.c   = (a < b);
            st    = as_signed(a) - as_signed(b);
            e.o   = (st > smax) || (st < smin);
            e.z   = (e.res == 0);
         end
         OP_MUL: begin
            p     = a * b;
            e.res = p & mask;
            e.hi  = p >> W;
            e.o   = (e.hi != 0);
            e.z   = (p == 0);
            e.lat = W + 1;
         end
         OP_DIV: begin
            if (b == 0) begin
               e.res = mask;
               e.hi  = a;
               e.d   = 1;
            end else begin
               e.res = a / b;
               e.hi  = a % b;
               e.z   = (e.res == 0);
               e.lat = W + 1;
            end
         end
         default: e.i = 1;
      endcase
      return e;
   endfunction

   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int lat;
      e = model(op, a, b);
      opcode = op; operand_1 = a; operand_2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      operand_1 = W'($urandom);
      operand_2 = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, e.lat);
      check({tag, " result"}, result, e.res);
      check({tag, " result_hi"}, result_hi, e.hi);
      check({tag, " carry"}, carry, e.c);
      check({tag, " zero"}, zero, e.z);
      check({tag, " overflow"}, overflow, e.o);
      check({tag, " div_by_zero"}, div_by_zero, e.d);
      check({tag, " illegal_op"}, illegal_op, e.i);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " retire in_ready"}, in_ready, 1);
      check({tag, " retire out_valid"}, out_valid, 0);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " out_valid"}, out_valid, 0);
      check({tag, " in_ready"}, in_ready, 1);
      check({tag, " result"}, result, 0);
      check({tag, " result_hi"}, result_hi, 0);
      check({tag, " flags"}, {carry, zero, overflow, div_by_zero, illegal_op}, 0);
   endtask

   initial begin
      int lat;
      logic [2:0] rop;
      // Reset behaviour
      #1 check_idle_zero("reset_during");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      check_idle_zero("reset_after");

      // Directed arithmetic
      do_op("add_10_5", OP_ADD, 19'd10, 19'd5);
      do_op("sub_10_5", OP_SUB, 19'd10, 19'd5);
      do_op("inc_10", OP_INC, 19'd10, 19'd0);
      do_op("dec_10", OP_DEC, 19'd10, 19'd0);
      do_op("add_wrap", OP_ADD, 19'h7FFFF, 19'd1);
      do_op("add_ovf", OP_ADD, 19'h3FFFF, 19'd1);
      do_op("inc_ovf", OP_INC, 19'h3FFFF, 19'd0);
      do_op("dec_ovf", OP_DEC, 19'h40000, 19'd0);
      do_op("dec_0", OP_DEC, 19'd0, 19'd0);
      do_op("sub_ovf", OP_SUB, 19'h40000, 19'd1);
      do_op("mul_3_4", OP_MUL, 19'd3, 19'd4);
      do_op("mul_max", OP_MUL, 19'h7FFFF, 19'h7FFFF);
      do_op("div_20_4", OP_DIV, 19'd20, 19'd4);
      do_op("div_23_4", OP_DIV, 19'd23, 19'd4);
      do_op("div_7_0", OP_DIV, 19'd7, 19'd0);
      do_op("div_max_1", OP_DIV, 19'h7FFFF, 19'd1);
      do_op("illegal", OP_BAD, 19'd9, 19'd9);

      // Backpressure with a second request stalled behind a MUL
      opcode = OP_MUL; operand_1 = 19'd3; operand_2 = 19'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      opcode = OP_ADD; operand_1 = 19'd100; operand_2 = 19'd23;
      lat = 0;
      while (!out_valid && lat < 100) begin
         check("bp busy in_ready", in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      check("bp mul latency", lat, W + 1);
      for (int k = 0; k < 5; k++) begin
         check("bp hold result", result, 12);
         check("bp hold result_hi", result_hi, 0);
         check("bp hold out_valid", out_valid, 1);
         check("bp hold in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp retire in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp stalled add latency", lat, 1);
      check("bp stalled add result", result, 123);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of a DIV
      opcode = OP_DIV; operand_1 = 19'd20; operand_2 = 19'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_idle_zero("midrst async");
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle_zero("midrst after");
      repeat (25) begin
         @(posedge clk); #1;
         check("midrst no stale out_valid", out_valid, 0);
      end
      do_op("post_rst_add", OP_ADD, 19'd1234, 19'd4321);

      // Random ops against the reference model
      for (int n = 0; n < 60; n++) begin
         rop = 3'($urandom_range(0, 7));
         if (n % 10 == 0) do_op("rand_div0", OP_DIV, W'($urandom), 19'd0);
         else do_op("rand", rop, W'($urandom), W'($urandom_range(0, 7) == 0 ? 0 : $urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
